// File: rtl/wb_seg7_ctrl.sv
// Wishbone B3 classic slave driving an 8-digit multiplexed 7-segment display.
// Define SEG7_BLINK_EN to add frame-based blinking (CTRL[2] writable, STATUS[8] phase).
module wb_seg7_ctrl #(
    parameter int SCAN_DIV     = 5000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        wb_clk_i,
    input  logic        wb_rstn_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic [7:0]  num_csn,
    output logic [7:0]  num_a_g
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
`ifdef SEG7_BLINK_EN
    localparam logic [31:0] CTRL_WMASK = 32'h0000_FF05;
`else
    localparam logic [31:0] CTRL_WMASK = 32'h0000_FF01;
`endif

    logic          r_ack;
    logic [31:0]   r_dat_o;
    logic [31:0]   r_data;
    logic [31:0]   r_ctrl;
    logic [7:0]    r_dp;
    logic [PW-1:0] r_pre;
    logic [2:0]    r_idx;
    logic [7:0]    r_csn;
    logic [7:0]    r_ag;

    logic          w_req;
    logic [1:0]    w_reg;
    logic [31:0]   w_bmask;
    logic [31:0]   w_rdata;
    logic          w_wrap;
    logic          w_phase;
    logic          w_blank;
    logic          w_lit;
    logic [7:0]    w_mask;
    logic [3:0]    w_nib;
    logic [6:0]    w_seg;
    logic          w_unused_adr;

    assign w_req        = wb_cyc_i & wb_stb_i & ~r_ack;
    assign w_reg        = wb_adr_i[3:2];
    assign w_unused_adr = ^{wb_adr_i[31:4], wb_adr_i[1:0]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_bmask[gi*8 +: 8] = {8{wb_sel_i[gi]}};
        end
    endgenerate

    always_comb begin
        w_rdata = '0;
        case (w_reg)
            2'd0: w_rdata = r_data;
            2'd1: w_rdata = r_ctrl;
            2'd2: w_rdata[7:0] = r_dp;
            default: begin
                w_rdata[2:0] = r_idx;
                w_rdata[8]   = w_phase;
            end
        endcase
    end

    // Register write and read capture share the edge that raises ack.
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            r_ack   <= 1'b0;
            r_dat_o <= '0;
            r_data  <= '0;
            r_ctrl  <= '0;
            r_dp    <= '0;
        end else begin
            r_ack <= w_req;
            if (w_req) begin
                if (wb_we_i) begin
                    case (w_reg)
                        2'd0: r_data <= (r_data & ~w_bmask) | (wb_dat_i & w_bmask);
                        2'd1: r_ctrl <= (r_ctrl & ~(w_bmask & CTRL_WMASK))
                                      | (wb_dat_i & w_bmask & CTRL_WMASK);
                        2'd2: r_dp   <= (r_dp & ~w_bmask[7:0]) | (wb_dat_i[7:0] & w_bmask[7:0]);
                        default: ;
                    endcase
                end else begin
                    r_dat_o <= w_rdata;
                end
            end
        end
    end

    assign w_wrap = (r_pre == PW'(SCAN_DIV - 1));

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            r_pre <= '0;
            r_idx <= '0;
        end else if (w_wrap) begin
            r_pre <= '0;
            r_idx <= r_idx + 3'd1;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

`ifdef SEG7_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    logic [FW-1:0] r_frame;
    logic          r_phase;

    // A frame ends when the index leaves digit 7.
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            r_frame <= '0;
            r_phase <= 1'b0;
        end else if (w_wrap && r_idx == 3'd7) begin
            if (r_frame == FW'(BLINK_FRAMES - 1)) begin
                r_frame <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_frame <= r_frame + 1'b1;
            end
        end
    end

    assign w_phase = r_phase;
    assign w_blank = r_ctrl[2] & r_phase;
`else
    logic [31:0] w_unused_blink;
    assign w_unused_blink = 32'(BLINK_FRAMES);
    assign w_phase = 1'b0;
    assign w_blank = 1'b0;
`endif

    assign w_mask = r_ctrl[15:8];
    assign w_nib  = r_data[{r_idx, 2'b00} +: 4];
    assign w_lit  = r_ctrl[0] & w_mask[r_idx] & ~w_blank;

    always_comb begin
        w_seg = 7'h00;
        case (w_nib)
            4'h0: w_seg = 7'h3F;
            4'h1: w_seg = 7'h06;
            4'h2: w_seg = 7'h5B;
            4'h3: w_seg = 7'h4F;
            4'h4: w_seg = 7'h66;
            4'h5: w_seg = 7'h6D;
            4'h6: w_seg = 7'h7D;
            4'h7: w_seg = 7'h07;
            4'h8: w_seg = 7'h7F;
            4'h9: w_seg = 7'h6F;
            4'hA: w_seg = 7'h77;
            4'hB: w_seg = 7'h7C;
            4'hC: w_seg = 7'h39;
            4'hD: w_seg = 7'h5E;
            4'hE: w_seg = 7'h79;
            default: w_seg = 7'h71;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            r_csn <= 8'hFF;
            r_ag  <= 8'h00;
        end else if (w_lit) begin
            r_csn <= ~(8'h01 << r_idx);
            r_ag  <= {r_dp[r_idx], w_seg};
        end else begin
            r_csn <= 8'hFF;
            r_ag  <= 8'h00;
        end
    end

    assign wb_ack_o = r_ack;
    assign wb_dat_o = r_dat_o;
    assign num_csn  = r_csn;
    assign num_a_g  = r_ag;

endmodule
